// File: rtl/bcam_ctrl.sv
// Sequencing controller for an ENTRIES x WIDTH binary CAM array: command FSM, valid tracking,
// allocation and match priority encoding. Define BCAM_CTRL_STATS_EN for hit/miss counters.
module bcam_ctrl #(
  parameter int ENTRIES = 8,
  parameter int WIDTH   = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [WIDTH-1:0]   req_data,
  input  logic [IDX_W-1:0]   req_idx,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic               resp_multi,
  output logic [IDX_W-1:0]   resp_idx,
  output logic [ENTRIES-1:0] array_we,
  output logic               array_rst,
  output logic [WIDTH-1:0]   array_search_word,
  input  logic [ENTRIES-1:0] array_match,
  output logic               full,
  output logic [IDX_W:0]     valid_count,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
);

  typedef enum logic [2:0] {IDLE, WRITE, SEARCH, RESP, FLUSH} state_t;

  state_t             state;
  logic [ENTRIES-1:0] valid;
  logic [IDX_W-1:0]   victim;
  logic [IDX_W-1:0]   alloc_q;
  logic               alloc_full_q;
  logic               flush_pulse;

  logic [IDX_W-1:0]   free_idx;
  logic               free_found;
  logic [IDX_W-1:0]   first_hit;
  logic [ENTRIES-1:0] masked;
  logic [IDX_W:0]     match_cnt;
  logic [IDX_W-1:0]   alloc;

  function automatic logic [IDX_W:0] popcount(input logic [ENTRIES-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) c = c + {{IDX_W{1'b0}}, v[i]};
    return c;
  endfunction

  assign req_ready   = (state == IDLE) && !rst;
  assign array_rst   = rst | flush_pulse;
  assign valid_count = popcount(valid);
  assign full        = (valid_count == (IDX_W+1)'(ENTRIES));
  assign masked      = array_match & valid;
  assign match_cnt   = popcount(masked);

  // Descending scans so the lowest qualifying index is the last one assigned.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    first_hit  = '0;
    for (int unsigned i = ENTRIES; i > 0; i--) begin
      if (!valid[i-1]) begin
        free_idx   = IDX_W'(i-1);
        free_found = 1'b1;
      end
      if (masked[i-1]) first_hit = IDX_W'(i-1);
    end
  end

  assign alloc = free_found ? free_idx : victim;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      valid             <= '0;
      victim            <= '0;
      alloc_q           <= '0;
      alloc_full_q      <= 1'b0;
      flush_pulse       <= 1'b0;
      resp_valid        <= 1'b0;
      resp_hit          <= 1'b0;
      resp_multi        <= 1'b0;
      resp_idx          <= '0;
      array_we          <= '0;
      array_search_word <= '0;
    end else begin
      array_we    <= '0;
      flush_pulse <= 1'b0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_multi  <= 1'b0;
      resp_idx    <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            case (req_op)
              2'b00: begin
                array_search_word <= req_data;
                state             <= SEARCH;
              end
              2'b01: begin
                // Row enable is registered, so the allocation is resolved at accept time.
                array_search_word <= req_data;
                array_we          <= {{(ENTRIES-1){1'b0}}, 1'b1} << alloc;
                alloc_q           <= alloc;
                alloc_full_q      <= !free_found;
                state             <= WRITE;
              end
              2'b10: begin
                flush_pulse <= 1'b1;
                state       <= FLUSH;
              end
              default: valid[req_idx] <= 1'b0;
            endcase
          end
        end
        WRITE: begin
          valid[alloc_q] <= 1'b1;
          if (alloc_full_q) victim <= victim + 1'b1;
          resp_valid <= 1'b1;
          resp_idx   <= alloc_q;
          state      <= RESP;
        end
        SEARCH: begin
          resp_valid <= 1'b1;
          resp_hit   <= |masked;
          resp_multi <= (match_cnt > (IDX_W+1)'(1));
          resp_idx   <= first_hit;
          state      <= RESP;
        end
        RESP: state <= IDLE;
        FLUSH: begin
          valid  <= '0;
          victim <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCAM_CTRL_STATS_EN
  logic resp_is_search;

  always_ff @(posedge clk) begin
    if (rst || state == FLUSH) begin
      resp_is_search <= 1'b0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      resp_is_search <= (state == SEARCH);
      if (state == RESP && resp_is_search) begin
        if (resp_hit) begin
          if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
        end else begin
          if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: doc/bcam_ctrl.md
Name: bcam_ctrl

Overview:
Sequencing controller for an ENTRIES x WIDTH binary CAM array built from our single-bit CAM cells. It accepts search, write, flush and invalidate commands over a valid/ready port and drives the array's row write-enables, search word and reset. It tracks entry valid bits, allocates entries on write, and priority-encodes the array match lines into a hit/index response. It sits between the lookup client and the CAM array; the array itself stays outside this block.

Parameters:
ENTRIES, 8, number of CAM rows (power of two, 2..64)
WIDTH, 8, bits per CAM word
IDX_W, 3, index width, equal to log2(ENTRIES)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
req_valid  input  1  command valid
req_ready  output  1  controller can accept a command
req_op  input  2  00 search, 01 write, 10 flush, 11 invalidate
req_data  input  WIDTH  search or write word
req_idx  input  IDX_W  target entry for invalidate
resp_valid  output  1  one-cycle response pulse
resp_hit  output  1  search hit; 0 for a write response
resp_multi  output  1  more than one valid entry matched
resp_idx  output  IDX_W  lowest matching index (search) or written index (write)
array_we  output  ENTRIES  one-hot row write enable
array_rst  output  1  array clear
array_search_word  output  WIDTH  word broadcast to every row
array_match  input  ENTRIES  per-row match lines from the array (combinational)
full  output  1  all entries valid
valid_count  output  IDX_W+1  number of valid entries
hit_count  output  16  saturating hit counter (optional feature)
miss_count  output  16  saturating miss counter (optional feature)

Behaviour:
- Reset is synchronous and active-high on rst, clocked by clk.
- During reset: state goes to IDLE; valid[] is cleared; the victim pointer goes to 0; req_ready=0; resp_* = 0; array_we = 0; array_search_word = 0; counters = 0.
- array_rst = rst OR flush_pulse. This is a combinational OR of registered terms.
- req_ready = 1 only in IDLE and not in reset. A command is accepted on req_valid && req_ready; op, data and idx are captured into registers.
- FSM states: IDLE, WRITE, SEARCH, RESP, FLUSH.
- Transitions: IDLE -> WRITE, SEARCH or FLUSH by op. Invalidate stays in IDLE. WRITE -> RESP. SEARCH -> RESP. FLUSH -> IDLE. RESP -> IDLE.
- Write, accepted in cycle T:
  - In cycle T+1 (WRITE state): array_search_word = data and array_we is one-hot at the allocation index.
  - Allocation index = lowest invalid entry. If full, it is the victim pointer, which then increments mod ENTRIES.
  - valid[alloc] is set at the end of T+1.
  - In cycle T+2: resp_valid=1, resp_hit=0, resp_multi=0, resp_idx=alloc.
- Search, accepted in cycle T:
  - In cycle T+1 (SEARCH state): array_search_word = data and array_we = 0. At the end of T+1, array_match & valid is registered into match_q.
  - In cycle T+2: resp_valid=1, resp_hit = |match_q, resp_idx = lowest set bit of match_q (0 on a miss), resp_multi = popcount(match_q) > 1.
- Flush: in cycle T+1, array_rst=1 for one cycle, all valid bits cleared, victim pointer reset to 0. No response is issued.
- Invalidate: at the end of cycle T, valid[req_idx] is cleared. There is no array activity, no response, and the block returns to IDLE immediately. Invalidating an already-invalid entry is a no-op.
- array_search_word holds its last value in IDLE.
- Responses have no backpressure. Throughput is one command per 3 cycles for search/write, 2 for flush, 1 for invalidate.
- full = (valid_count == ENTRIES). valid_count updates in the same cycle as the valid bits.
- Reset asserted mid-operation aborts it. No response is issued; any pending write is lost (its valid bit is not set).
- Writing a duplicate value is allowed. A subsequent search then reports resp_multi=1.

Optional Feature:
BCAM_CTRL_STATS_EN
- Defined: hit_count and miss_count increment in the RESP cycle of each search, according to resp_hit. They saturate at 0xFFFF and clear on rst or flush.
- Undefined: no counter logic; hit_count and miss_count are tied to 0, so the port list is unchanged.

Test Plan:
- Reset, then write 0xA5 -> array_we=0x01 at T+1; resp at T+2 with idx=0, hit=0; valid_count=1.
- After the above, search 0xA5 -> array_search_word=0xA5 at T+1; resp hit=1, idx=0, multi=0. Search 0x3C -> hit=0, idx=0.
- Write 8 distinct words -> full=1. Write 0x11 -> replaces idx 0. Write 0x22 -> replaces idx 1. Searching the overwritten word misses.
- Write 0x55 to idx 0 and to idx 1 -> search 0x55 gives hit=1, idx=0, multi=1. Invalidate idx 0 -> search gives idx=1, multi=0.
- Flush after 3 writes -> array_rst pulse lasts exactly 1 cycle; valid_count=0, full=0; the next write allocates idx 0; all searches miss.
- Assert rst in the SEARCH cycle -> no resp_valid; req_ready=1 one cycle after rst deasserts. With BCAM_CTRL_STATS_EN: 3 hits and 2 misses -> hit_count=3, miss_count=2.
